apb_master: RTL and testbench

APB_MASTER -- requirements
Module: apb_master

---
 rtl/apb_master.sv | 108 ++++++++++
 tb/tb_apb_master.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// APB requester: turns one local command into one SETUP/ACCESS transfer
// and returns a single response, with a bounded wait for PREADY.
module apb_master #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  rsp_timeout,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] wcnt;
  logic          done_ok;
  logic          done_to;

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == RESP);

  always_comb begin
    state_n = state;
    done_ok = 1'b0;
    done_to = 1'b0;
    unique case (state)
      IDLE:   if (cmd_valid) state_n = SETUP;
      SETUP:  state_n = ACCESS;
      ACCESS: begin
        // a late PREADY on the last allowed cycle still wins
        if (PREADY) begin
          done_ok = 1'b1;
          state_n = RESP;
        end else if (wcnt == TO_LAST) begin
          done_to = 1'b1;
          state_n = RESP;
        end
      end
      RESP:   if (rsp_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state       <= IDLE;
      PSEL        <= 1'b0;
      PENABLE     <= 1'b0;
      PWRITE      <= 1'b0;
      PADDR       <= '0;
      PWDATA      <= '0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
      wcnt        <= '0;
    end else begin
      state   <= state_n;
      PSEL    <= (state_n == SETUP) || (state_n == ACCESS);
      PENABLE <= (state_n == ACCESS);
      if (cmd_valid && cmd_ready) begin
        PADDR  <= cmd_addr;
        PWRITE <= cmd_write;
        PWDATA <= cmd_wdata;
      end
      if (state == SETUP)
        wcnt <= '0;
      else if (state == ACCESS && !PREADY && wcnt != TO_LAST)
        wcnt <= wcnt + CW'(1);
      if (done_ok) begin
        rsp_err     <= PSLVERR;
        rsp_timeout <= 1'b0;
        rsp_rdata   <= PWRITE ? '0 : PRDATA;
      end else if (done_to) begin
        rsp_err     <= 1'b1;
        rsp_timeout <= 1'b1;
        rsp_rdata   <= '0;
      end
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: directed corner cases plus random transfers
// against a completer/memory model and a transaction-level expectation.
module tb_apb_master;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESET = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  int total = 0;
  int fails = 0;
  logic [DW-1:0] mem [1024];

  apb_master #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_write(cmd_write), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA),
    .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // waits >= TO means the completer never answers
  task automatic txn(input logic wr, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input int waits,
                     input logic err, input int hold);
    int n;
    int cyc;
    int exp_n;
    logic timed;
    logic [DW-1:0] exp_rd;
    logic exp_err;
    timed = (waits >= TO);
    exp_n = timed ? TO : waits + 1;
    exp_err = timed ? 1'b1 : err;
    exp_rd = (timed || wr) ? '0 : mem[a];
    @(negedge PCLK);
    chk("accept_ready", cmd_ready, 1'b1);
    chk("accept_norsp", rsp_valid, 1'b0);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr = a;
    cmd_wdata = wd;
    rsp_ready = (hold == 0);
    cyc = 0;
    @(negedge PCLK);
    cyc++;
    cmd_valid = 1'b0;
    cmd_addr = AW'($urandom);
    cmd_wdata = $urandom;
    chk("setup_psel", {PSEL, PENABLE}, 2'b10);
    chk("setup_addr", PADDR, a);
    chk("setup_write", PWRITE, wr);
    if (wr) chk("setup_wdata", PWDATA, wd);
    chk("setup_ready", cmd_ready, 1'b0);
    PREADY = 1'($urandom);
    PSLVERR = 1'($urandom);
    PRDATA = $urandom;
    n = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge PCLK);
      cyc++;
      if (!(PSEL && PENABLE)) break;
      n++;
      chk("access_addr", PADDR, a);
      chk("access_write", PWRITE, wr);
      if (wr) chk("access_wdata", PWDATA, wd);
      PREADY = !timed && (n == waits + 1);
      PSLVERR = PREADY ? err : 1'($urandom);
      PRDATA = PREADY ? mem[a] : $urandom;
    end
    chk("access_len", n, exp_n);
    chk("resp_bus", {PSEL, PENABLE}, 2'b00);
    chk("resp_valid", rsp_valid, 1'b1);
    chk("resp_err", rsp_err, exp_err);
    chk("resp_to", rsp_timeout, timed);
    chk("resp_rdata", rsp_rdata, exp_rd);
    if (wr && !timed && !err) mem[a] = wd;
    PREADY = 1'($urandom);
    PSLVERR = 1'($urandom);
    PRDATA = $urandom;
    for (int i = 0; i < hold; i++) begin
      @(negedge PCLK);
      cyc++;
      chk("hold_valid", rsp_valid, 1'b1);
      chk("hold_ready", cmd_ready, 1'b0);
      chk("hold_payload", {rsp_err, rsp_timeout, rsp_rdata},
          {exp_err, timed, exp_rd});
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    cyc++;
    chk("idle_ready", cmd_ready, 1'b1);
    chk("idle_norsp", rsp_valid, 1'b0);
    chk("cycles", cyc, exp_n + 3 + hold);
    rsp_ready = 1'b0;
    PREADY = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[2] = 32'hCAFEBABE;
    #12;
    chk("rst_bus", {PSEL, PENABLE, PWRITE}, 3'b000);
    chk("rst_addr", PADDR, '0);
    chk("rst_wdata", PWDATA, '0);
    chk("rst_rsp", {rsp_valid, rsp_err, rsp_timeout}, 3'b000);
    chk("rst_rdata", rsp_rdata, '0);
    chk("rst_ready", cmd_ready, 1'b1);
    @(negedge PCLK);
    PRESET = 1'b0;

    txn(1'b1, 10'h001, 32'hDEADBEEF, 0, 1'b0, 0);
    txn(1'b0, 10'h002, '0, 3, 1'b0, 0);
    chk("cafe_const", mem[2], 32'hCAFEBABE);
    txn(1'b0, 10'h003, '0, 0, 1'b1, 0);
    txn(1'b0, 10'h004, '0, TO, 1'b0, 0);
    txn(1'b1, 10'h005, 32'h12345678, TO, 1'b0, 1);
    txn(1'b0, 10'h006, '0, TO - 1, 1'b0, 0);
    txn(1'b0, 10'h001, '0, 1, 1'b0, 5);

    // reset in the middle of ACCESS
    @(negedge PCLK);
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 10'h3FF;
    cmd_wdata = 32'hA5A5A5A5;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    PREADY = 1'b0;
    @(negedge PCLK);
    chk("pre_rst_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1;
    chk("async_rst_bus", {PSEL, PENABLE}, 2'b00);
    chk("async_rst_addr", PADDR, '0);
    chk("async_rst_rsp", rsp_valid, 1'b0);
    @(negedge PCLK);
    PRESET = 1'b0;
    @(negedge PCLK);
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_norsp", rsp_valid, 1'b0);
    txn(1'b1, 10'h007, 32'h0BADF00D, 0, 1'b0, 0);
    txn(1'b0, 10'h007, '0, 2, 1'b0, 2);

    for (int t = 0; t < 25; t++) begin
      int w;
      w = ($urandom_range(0, 5) == 0) ? TO + 2 : $urandom_range(0, 6);
      txn(1'($urandom), AW'($urandom_range(0, 15)), $urandom, w,
          ($urandom_range(0, 4) == 0), $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
